// File: rtl/regfile_sb.sv
// Multi-port integer register file with byte-lane write-back and a per-register pending bit.
// Optional same-cycle write-back forwarding on reads is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
   parameter  int XLEN = 32,
   parameter  int NREG = 32,
   parameter  int NRD  = 2,
   localparam int AW   = $clog2(NREG)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  we3,
   input  logic [AW-1:0]         a3,
   input  logic [XLEN-1:0]       wd3,
   input  logic [XLEN/8-1:0]     web,
   input  logic [NRD*AW-1:0]     ra,
   output logic [NRD*XLEN-1:0]   rd,
   output logic [NRD-1:0]        rs_busy,
   input  logic                  iss_en,
   input  logic [AW-1:0]         iss_rd
);

   localparam int NB = XLEN / 8;

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic [NREG-1:0] pend_q;
   logic [NREG-1:0] pend_d;
   logic            wb_valid_s;
   logic            iss_valid_s;

   function automatic logic [XLEN-1:0] lane_merge(input logic [XLEN-1:0] old_v,
                                                  input logic [XLEN-1:0] new_v,
                                                  input logic [NB-1:0]   be);
      logic [XLEN-1:0] res;
      for (int b = 0; b < NB; b++) begin
         res[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      end
      return res;
   endfunction

   assign wb_valid_s  = we3 && (a3 != '0);
   assign iss_valid_s = iss_en && (iss_rd != '0);

   // Next state: an issue to the same register as a write-back keeps it pending.
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         regs_d[r] = (wb_valid_s && (a3 == AW'(r))) ? lane_merge(regs_q[r], wd3, web) : regs_q[r];
         pend_d[r] = (iss_valid_s && (iss_rd == AW'(r))) ? 1'b1 :
                     (wb_valid_s && (a3 == AW'(r)))      ? 1'b0 : pend_q[r];
      end
      regs_d[0] = '0;
      pend_d[0] = 1'b0;
   end

   // State registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NREG; r++) begin
            regs_q[r] <= '0;
         end
         pend_q <= '0;
      end else begin
         for (int r = 0; r < NREG; r++) begin
            regs_q[r] <= regs_d[r];
         end
         pend_q <= pend_d;
      end
   end

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [AW-1:0]   addr_s;
      logic [XLEN-1:0] data_s;
      logic            busy_s;
      logic            zero_s;

      assign addr_s = ra[p*AW +: AW];
      assign zero_s = reset || (addr_s == '0);

      // Combinational read of one port, optionally merged with the in-flight write-back.
      always_comb begin
         data_s = regs_q[addr_s];
         busy_s = pend_q[addr_s];
`ifdef REGFILE_BYPASS_EN
         if (wb_valid_s && (a3 == addr_s)) begin
            data_s = lane_merge(regs_q[addr_s], wd3, web);
            busy_s = 1'b0;
         end else begin
            data_s = regs_q[addr_s];
            busy_s = pend_q[addr_s];
         end
`endif
      end

      assign rd[p*XLEN +: XLEN] = zero_s ? '0 : data_s;
      assign rs_busy[p]         = zero_s ? 1'b0 : busy_s;
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed table plus hand sequences on the default build, and a randomised
// reference-model run on a 64-bit, 16-entry, 3-port instance.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   // ---------------- default instance: XLEN=32, NREG=32, NRD=2 ----------------
   logic        we3, iss_en;
   logic [4:0]  a3, iss_rd, ra0, ra1;
   logic [31:0] wd3;
   logic [3:0]  web;
   logic [63:0] rd;
   logic [1:0]  rs_busy;

   regfile_sb u_dut (
      .clk(clk), .reset(reset), .we3(we3), .a3(a3), .wd3(wd3), .web(web),
      .ra({ra1, ra0}), .rd(rd), .rs_busy(rs_busy), .iss_en(iss_en), .iss_rd(iss_rd)
   );

   // ---------------- parametric instance: XLEN=64, NREG=16, NRD=3 --------------
   logic         r_we, r_iss;
   logic [3:0]   r_a3, r_issrd;
   logic [63:0]  r_wd;
   logic [7:0]   r_web;
   logic [11:0]  r_ra;
   logic [191:0] r_rd;
   logic [2:0]   r_busy;

   regfile_sb #(.XLEN(64), .NREG(16), .NRD(3)) u_dut2 (
      .clk(clk), .reset(reset), .we3(r_we), .a3(r_a3), .wd3(r_wd), .web(r_web),
      .ra(r_ra), .rd(r_rd), .rs_busy(r_busy), .iss_en(r_iss), .iss_rd(r_issrd)
   );

   logic [63:0] m_regs [16];
   logic [15:0] m_pend;

   typedef struct {
      logic        we3;
      logic [4:0]  a3;
      logic [31:0] wd3;
      logic [3:0]  web;
      logic        iss_en;
      logic [4:0]  iss_rd;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] e0;
      logic [31:0] e1;
      logic [1:0]  eb;
   } vec_t;

   vec_t tbl [16];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [3:0] be,
                        input logic ie, input logic [4:0] ir, input logic [4:0] r0, input logic [4:0] r1);
      we3 = w; a3 = a; wd3 = d; web = be; iss_en = ie; iss_rd = ir; ra0 = r0; ra1 = r1;
   endtask

   task automatic chk_ports(input string nm, input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb);
      chk({nm, ".rd0"}, {32'h0, rd[31:0]}, {32'h0, e0});
      chk({nm, ".rd1"}, {32'h0, rd[63:32]}, {32'h0, e1});
      chk({nm, ".busy"}, {62'h0, rs_busy}, {62'h0, eb});
   endtask

   function automatic logic [63:0] merge64(input logic [63:0] o, input logic [63:0] n, input logic [7:0] be);
      logic [63:0] res = o;
      for (int b = 0; b < 8; b++) begin
         if (be[b]) res[8*b +: 8] = n[8*b +: 8];
      end
      return res;
   endfunction

   initial begin
      // Reads are sampled before the edge, so each row's expected values see the state left by earlier rows.
      tbl[0]  = '{1'b0, 5'd0, 32'h0,        4'h0,    1'b0, 5'd0, 5'd0, 5'd5, 32'h0, 32'h0, 2'b00};
      tbl[1]  = '{1'b1, 5'd3, 32'h11223344, 4'hF,    1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00};
      tbl[2]  = '{1'b1, 5'd3, 32'hAABBCCDD, 4'b0101, 1'b0, 5'd0, 5'd3, 5'd0,
                  BYP ? 32'h11BB33DD : 32'h11223344, 32'h0, 2'b00};
      tbl[3]  = '{1'b0, 5'd0, 32'h0,        4'h0,    1'b0, 5'd0, 5'd3, 5'd0, 32'h11BB33DD, 32'h0, 2'b00};
      tbl[4]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 4'hF,    1'b1, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00};
      tbl[5]  = '{1'b0, 5'd0, 32'h0,        4'h0,    1'b0, 5'd0, 5'd0, 5'd3, 32'h0, 32'h11BB33DD, 2'b00};
      tbl[6]  = '{1'b0, 5'd0, 32'h0,        4'h0,    1'b1, 5'd7, 5'd7, 5'd7, 32'h0, 32'h0, 2'b00};
      tbl[7]  = '{1'b0, 5'd0, 32'h0,        4'h0,    1'b0, 5'd0, 5'd7, 5'd3, 32'h0, 32'h11BB33DD, 2'b01};
      tbl[8]  = '{1'b1, 5'd7, 32'h12345678, 4'hF,    1'b0, 5'd0, 5'd7, 5'd3,
                  BYP ? 32'h12345678 : 32'h0, 32'h11BB33DD, BYP ? 2'b00 : 2'b01};
      tbl[9]  = '{1'b0, 5'd0, 32'h0,        4'h0,    1'b0, 5'd0, 5'd7, 5'd7, 32'h12345678, 32'h12345678, 2'b00};
      tbl[10] = '{1'b1, 5'd7, 32'hFFFFFFFF, 4'h0,    1'b1, 5'd7, 5'd3, 5'd0, 32'h11BB33DD, 32'h0, 2'b00};
      tbl[11] = '{1'b0, 5'd0, 32'h0,        4'h0,    1'b0, 5'd0, 5'd7, 5'd0, 32'h12345678, 32'h0, 2'b01};
      tbl[12] = '{1'b1, 5'd7, 32'h0,        4'h0,    1'b1, 5'd5, 5'd5, 5'd3, 32'h0, 32'h11BB33DD, 2'b00};
      tbl[13] = '{1'b0, 5'd0, 32'h0,        4'h0,    1'b0, 5'd0, 5'd7, 5'd5, 32'h12345678, 32'h0, 2'b10};
      tbl[14] = '{1'b1, 5'd5, 32'hDEADBEEF, 4'hF,    1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00};
      tbl[15] = '{1'b0, 5'd0, 32'h0,        4'h0,    1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00};

      reset = 1'b1;
      drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd0, 5'd0);
      r_we = 1'b0; r_a3 = '0; r_wd = '0; r_web = '0; r_ra = '0; r_iss = 1'b0; r_issrd = '0;
      for (int r = 0; r < 16; r++) m_regs[r] = '0;
      m_pend = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         drive(tbl[i].we3, tbl[i].a3, tbl[i].wd3, tbl[i].web, tbl[i].iss_en, tbl[i].iss_rd, tbl[i].ra0, tbl[i].ra1);
         #1;
         chk_ports($sformatf("vec%0d", i), tbl[i].e0, tbl[i].e1, tbl[i].eb);
      end

      // Reset mid-run: x5 holds DEADBEEF and is made pending; writes/issues during reset are dropped.
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd5, 5'd5, 5'd0);
      @(negedge clk);
      reset = 1'b1;
      drive(1'b1, 5'd9, 32'hFFFFFFFF, 4'hF, 1'b1, 5'd9, 5'd5, 5'd9);
      #1;
      chk_ports("rst_hi0", 32'h0, 32'h0, 2'b00);
      @(negedge clk);
      chk_ports("rst_hi1", 32'h0, 32'h0, 2'b00);
      reset = 1'b0;
      drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd5, 5'd9);
      #1;
      chk_ports("rst_rel", 32'h0, 32'h0, 2'b00);

      // Bypass: x9=01020304 (issued on the same edge), then a partial write read in its own cycle.
      @(negedge clk);
      drive(1'b1, 5'd9, 32'h01020304, 4'hF, 1'b1, 5'd9, 5'd9, 5'd9);
      #1;
      chk_ports("byp_a", BYP ? 32'h01020304 : 32'h0, BYP ? 32'h01020304 : 32'h0, 2'b00);
      @(negedge clk);
      drive(1'b1, 5'd9, 32'hA0B0C0D0, 4'b0011, 1'b0, 5'd0, 5'd9, 5'd9);
      #1;
      chk_ports("byp_b", BYP ? 32'h0102C0D0 : 32'h01020304, BYP ? 32'h0102C0D0 : 32'h01020304,
                BYP ? 2'b00 : 2'b11);
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 5'd9, 5'd0);
      #1;
      chk_ports("byp_c", 32'h0102C0D0, 32'h0, 2'b00);

      // Randomised run on the parametric instance against a reference model.
      for (int c = 0; c < 10000; c++) begin
         @(negedge clk);
         r_we    = ($urandom_range(0, 1) == 1);
         r_a3    = 4'($urandom_range(0, 15));
         r_wd    = {$urandom, $urandom};
         r_web   = 8'($urandom_range(0, 255));
         r_iss   = ($urandom_range(0, 2) == 0);
         r_issrd = 4'($urandom_range(0, 15));
         r_ra    = 12'($urandom_range(0, 4095));
         #1;
         for (int p = 0; p < 3; p++) begin
            logic [3:0]  a;
            logic [63:0] ed;
            logic        eb;
            a  = r_ra[p*4 +: 4];
            ed = m_regs[a];
            eb = m_pend[a];
            if (BYP && r_we && (r_a3 == a)) begin
               ed = merge64(m_regs[a], r_wd, r_web);
               eb = 1'b0;
            end
            if (a == 4'd0) begin
               ed = 64'h0;
               eb = 1'b0;
            end
            chk($sformatf("rnd%0d.rd%0d", c, p), r_rd[p*64 +: 64], ed);
            chk($sformatf("rnd%0d.busy%0d", c, p), {63'h0, r_busy[p]}, {63'h0, eb});
         end
         if (r_we && (r_a3 != 4'd0)) begin
            m_regs[r_a3] = merge64(m_regs[r_a3], r_wd, r_web);
            m_pend[r_a3] = 1'b0;
         end
         if (r_iss && (r_issrd != 4'd0)) m_pend[r_issrd] = 1'b1;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port integer register file with byte-lane writes and a per-register pending (scoreboard) bit. It replaces the fixed 32x32 two-read-port file in the single-cycle/pipelined core. It supplies N combinational read ports, one byte-enabled write-back port, and busy flags the hazard unit uses to stall consumers of in-flight results. Register 0 is hardwired to zero and is never pending.

## Interface
Parameters:
- XLEN, 32, data width in bits; must be a multiple of 8.
- NREG, 32, number of registers; power of two, at least 2.
- NRD, 2, number of read ports, 1 to 4.
- AW, $clog2(NREG), derived address width; not overridden.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all registers and pending bits
- we3  in  1  write-back enable
- a3  in  AW  write-back register index
- wd3  in  XLEN  write-back data
- web  in  XLEN/8  write byte enables; bit i covers wd3[8i+7:8i]
- ra  in  NRD*AW  packed read addresses; port i is ra[i*AW +: AW]
- rd  out  NRD*XLEN  packed read data; port i is rd[i*XLEN +: XLEN]
- rs_busy  out  NRD  port i's register has an outstanding producer
- iss_en  in  1  issue of an instruction that will write iss_rd
- iss_rd  in  AW  destination register being issued

## Operation
- Storage: NREG x XLEN flops. Pending bit vector pend[NREG-1:0].
- Write: on a clk rising edge with we3=1 and a3≠0, each byte lane with web[i]=1 takes wd3's byte. Other lanes hold.
  - Writes with a3=0 are discarded.
  - we3=1 with web=0 writes no data but still clears pend[a3].
- Pending:
  - On the edge, iss_en=1 with iss_rd≠0 sets pend[iss_rd].
  - we3=1 with a3≠0 clears pend[a3].
  - Same edge, same register for issue and write-back: set wins (new producer supersedes).
  - Different registers: both actions apply.
  - pend[0] is constant 0.
- Read: rd[i] = 0 when ra[i]=0; otherwise the stored value (merged with bypass when REGFILE_BYPASS_EN is defined).
- rs_busy[i] = pend[ra[i]], forced 0 when ra[i]=0. It is also forced 0 when a same-cycle bypass hit applies (see Configuration).
- Duplicate read addresses across ports return identical data and busy.

## Timing
- Read path is combinational from ra, state and (with bypass) we3/a3/wd3/web. Zero-cycle latency.
- Write data is visible on the un-bypassed path the cycle after the write edge.
- A pending set is visible on rs_busy the cycle after the issue edge. iss_en does not affect rs_busy in its own cycle.
- Reset asserted at any time: all registers become 0 and pend becomes 0 immediately. rd reads 0 and rs_busy is 0 while reset is high.
- First active edge after reset deassertion performs normal writes and issues.
- Writes and issues coincident with reset are ignored.

## Configuration
- REGFILE_BYPASS_EN defined: a read port with ra[i]=a3≠0 while we3=1 returns the byte-wise merge. Lanes with web set come from wd3; other lanes come from the stored value. rs_busy[i] is forced 0 for that port that cycle.
- Undefined: no forwarding. The read returns the pre-write stored value, and rs_busy reflects pend unchanged until the edge. The hazard unit stalls one extra cycle.

## Test plan
- Reset then read: assert reset mid-run after writing x5=0xDEADBEEF. Required: rd reads 0 on all ports, rs_busy=0; after release, reading x5 returns 0x00000000.
- Byte-lane write: write x3=0x11223344 with web=4'hF, then wd3=0xAABBCCDD with web=4'b0101. Required next cycle: x3=0x11BB33DD.
- x0 immunity: we3=1, a3=0, wd3=0xFFFFFFFF, plus iss_en with iss_rd=0. Required: ra=0 reads 0, rs_busy=0 on every port.
- Scoreboard: issue x7 at cycle n; required rs_busy=1 for ra=7 from n+1. Write-back x7 at cycle m; required rs_busy=0 from m+1 (from m with bypass). Same-edge issue and write-back of x7: required pend[7] stays 1.
- Bypass, with the macro defined: stored x9=0x01020304, then write 0xA0B0C0D0 with web=4'b0011. Required: same-cycle read gives 0x0102C0D0 and busy=0. Without the macro, the same-cycle read gives 0x01020304.
- Parametric run at XLEN=64, NREG=16, NRD=3: random writes, issues and reads against a reference model. Required: no mismatches over 10k cycles.
